// File: rtl/bf_program_loader.sv
// ---------------------------------------------------------------------------
// bf_program_loader
//
// Purpose:
//   Writer side of the core's program ROM interface. Accepts a byte stream
//   of brainfuck source over a valid/ready handshake, encodes each opcode
//   character into the core's 3-bit instruction encoding and writes the
//   opcodes sequentially into program memory starting at address 0.
//   Non-opcode characters are accepted and dropped. Bracket balance is
//   tracked on the fly so that a malformed program never reports done.
//
// Parameters:
//   ADDR_WIDTH  - program memory address width (capacity 2**ADDR_WIDTH)
//   DEPTH_WIDTH - width of the bracket nesting counter
//
// Ports:
//   clock           - system clock, all state on rising edge
//   reset_n         - asynchronous active-low reset
//   start           - single-cycle pulse, begins or restarts a load
//   in_valid        - source byte valid
//   in_ready        - loader accepts a byte this cycle
//   in_data         - ASCII source byte
//   in_last         - final byte of the program (qualified by in_valid)
//   pmem_we         - program memory write enable, one cycle per opcode
//   pmem_addr       - program memory write address
//   pmem_data_write - encoded opcode
//   done            - load completed with balanced brackets
//   error           - load aborted
//   error_code      - 0 none, 1 unmatched ']', 2 unclosed '[', 3 overflow
//   prog_length     - number of opcodes written
// ---------------------------------------------------------------------------
module bf_program_loader #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  pmem_we,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [2:0]            pmem_data_write,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic [ADDR_WIDTH:0]   prog_length
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [2:0] OP_OPEN  = 3'd4;
    localparam logic [2:0] OP_CLOSE = 3'd5;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNMATCHED = 2'd1;
    localparam logic [1:0] ERR_UNCLOSED  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

    localparam logic [ADDR_WIDTH:0]    LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic                    inReady_q;
    logic                    pmemWe_q, pmemWe_d;
    logic [ADDR_WIDTH-1:0]   pmemAddr_q, pmemAddr_d;
    logic [2:0]              pmemData_q, pmemData_d;
    logic                    done_q;
    logic                    error_q;
    logic [1:0]              errCode_q, errCode_d;
    logic [ADDR_WIDTH:0]     progLen_q, progLen_d;
    logic [DEPTH_WIDTH-1:0]  depth_q, depth_d;

    logic                    isOp;
    logic [2:0]              opCode;
    logic                    accept;
    logic                    capacityFull;
    logic                    depthFull;

    // Character decoder: maps the eight brainfuck opcode characters onto
    // the core's instruction encoding. Anything else is a comment byte.
    always_comb begin
        isOp   = 1'b1;
        opCode = 3'd0;
        unique case (in_data)
            8'h2B:   opCode = 3'd0;  // '+'
            8'h2D:   opCode = 3'd1;  // '-'
            8'h3E:   opCode = 3'd2;  // '>'
            8'h3C:   opCode = 3'd3;  // '<'
            8'h5B:   opCode = 3'd4;  // '['
            8'h5D:   opCode = 3'd5;  // ']'
            8'h2E:   opCode = 3'd6;  // '.'
            8'h2C:   opCode = 3'd7;  // ','
            default: isOp   = 1'b0;
        endcase
    end

    // in_ready is registered, and is only ever high while in LOAD, so the
    // handshake alone qualifies a byte. The program is full once the count
    // reaches 2**ADDR_WIDTH, which is exactly when its top bit is set.
    assign accept       = in_valid && inReady_q;
    assign capacityFull = progLen_q[ADDR_WIDTH];
    assign depthFull    = &depth_q;

    // Next-state logic. A start pulse overrides everything, including a
    // byte offered in the same cycle, so a restart always begins cleanly.
    // Within LOAD a faulting byte is never written, and a fault raised by
    // the in_last byte takes priority over the end-of-program balance check.
    always_comb begin
        state_d    = state_q;
        pmemWe_d   = 1'b0;
        pmemAddr_d = pmemAddr_q;
        pmemData_d = pmemData_q;
        errCode_d  = errCode_q;
        progLen_d  = progLen_q;
        depth_d    = depth_q;

        if (start) begin
            state_d   = ST_LOAD;
            progLen_d = '0;
            depth_d   = '0;
            errCode_d = ERR_NONE;
        end else if (state_q == ST_LOAD && accept) begin
            if (isOp && capacityFull) begin
                state_d   = ST_ERROR;
                errCode_d = ERR_OVERFLOW;
            end else if (isOp && opCode == OP_OPEN && depthFull) begin
                state_d   = ST_ERROR;
                errCode_d = ERR_OVERFLOW;
            end else if (isOp && opCode == OP_CLOSE && depth_q == '0) begin
                state_d   = ST_ERROR;
                errCode_d = ERR_UNMATCHED;
            end else begin
                if (isOp) begin
                    pmemWe_d   = 1'b1;
                    pmemAddr_d = progLen_q[ADDR_WIDTH-1:0];
                    pmemData_d = opCode;
                    progLen_d  = progLen_q + LEN_ONE;
                    if (opCode == OP_OPEN) begin
                        depth_d = depth_q + DEPTH_ONE;
                    end else if (opCode == OP_CLOSE) begin
                        depth_d = depth_q - DEPTH_ONE;
                    end
                end
                if (in_last) begin
                    if (depth_d == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_ERROR;
                        errCode_d = ERR_UNCLOSED;
                    end
                end
            end
        end
    end

    // State and datapath registers. in_ready, done and error are registered
    // off the next state so they change on the very edge the FSM moves,
    // which stops any byte being accepted after in_last or a fault.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            inReady_q  <= 1'b0;
            pmemWe_q   <= 1'b0;
            pmemAddr_q <= '0;
            pmemData_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            errCode_q  <= ERR_NONE;
            progLen_q  <= '0;
            depth_q    <= '0;
        end else begin
            state_q    <= state_d;
            inReady_q  <= (state_d == ST_LOAD);
            pmemWe_q   <= pmemWe_d;
            pmemAddr_q <= pmemAddr_d;
            pmemData_q <= pmemData_d;
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERROR);
            errCode_q  <= errCode_d;
            progLen_q  <= progLen_d;
            depth_q    <= depth_d;
        end
    end

    assign in_ready        = inReady_q;
    assign pmem_we         = pmemWe_q;
    assign pmem_addr       = pmemAddr_q;
    assign pmem_data_write = pmemData_q;
    assign done            = done_q;
    assign error           = error_q;
    assign error_code      = errCode_q;
    assign prog_length     = progLen_q;

endmodule
